// File: rtl/run_monitor.sv
// run_monitor: sequences the RV32I core reset, counts RUN cycles, fingerprints the
// core's memory-write stream and reports done/pass/timeout for self-checking runs.
module run_monitor #(
  parameter int unsigned        DATA_W     = 32,
  parameter int unsigned        CNT_W      = 32,
  parameter int unsigned        RST_HOLD   = 2,
  parameter logic [CNT_W-1:0]   TIMEOUT    = CNT_W'(100000),
  parameter logic [DATA_W-1:0]  SIG_SEED   = '0,
  parameter logic [DATA_W-1:0]  EXPECT_SIG = '0,
  parameter bit                 CHECK_SIG  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              complete,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timed_out,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  wr_count,
  output logic [DATA_W-1:0] signature
);

  typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        hold_q, hold_d;
  logic              core_reset_q, core_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timed_out_q, timed_out_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic [DATA_W-1:0] signature_q, signature_d;

  logic [CNT_W-1:0]  cyc_inc;
  logic [CNT_W-1:0]  wr_inc;
  logic [DATA_W-1:0] sig_upd;

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    core_reset_d  = core_reset_q;
    busy_d        = busy_q;
    done_d        = done_q;
    pass_d        = pass_q;
    timed_out_d   = timed_out_q;
    cycle_count_d = cycle_count_q;
    wr_count_d    = wr_count_q;
    signature_d   = signature_q;

    // Saturating counters; the signature update is shared by the pass check so a
    // write in the completing cycle is part of the judged signature.
    cyc_inc = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + 1'b1;
    wr_inc  = (wr_count_q == '1) ? wr_count_q : wr_count_q + 1'b1;
    sig_upd = wr_valid ? ({signature_q[DATA_W-2:0], signature_q[DATA_W-1]} ^ wr_data)
                       : signature_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d       = HOLD;
          hold_d        = 8'(RST_HOLD - 1);
          core_reset_d  = 1'b1;
          busy_d        = 1'b1;
          done_d        = 1'b0;
          pass_d        = 1'b0;
          timed_out_d   = 1'b0;
          cycle_count_d = '0;
          wr_count_d    = '0;
          signature_d   = SIG_SEED;
        end
      end
      HOLD: begin
        if (hold_q == '0) begin
          state_d      = RUN;
          core_reset_d = 1'b0;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      RUN: begin
        cycle_count_d = cyc_inc;
        signature_d   = sig_upd;
        if (wr_valid) begin
          wr_count_d = wr_inc;
        end
        if (complete) begin
          state_d      = DONE;
          core_reset_d = 1'b1;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          pass_d       = !CHECK_SIG || (sig_upd == EXPECT_SIG);
        end else if (cyc_inc == TIMEOUT) begin
          state_d      = DONE;
          core_reset_d = 1'b1;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          timed_out_d  = 1'b1;
          pass_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      core_reset_q  <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timed_out_q   <= 1'b0;
      cycle_count_q <= '0;
      wr_count_q    <= '0;
      signature_q   <= SIG_SEED;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      core_reset_q  <= core_reset_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      timed_out_q   <= timed_out_d;
      cycle_count_q <= cycle_count_d;
      wr_count_q    <= wr_count_d;
      signature_q   <= signature_d;
    end
  end

  assign core_reset  = core_reset_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timed_out   = timed_out_q;
  assign cycle_count = cycle_count_q;
  assign wr_count    = wr_count_q;
  assign signature   = signature_q;

endmodule
